// File: rtl/pq_pkg.sv
// Shared types and ordering rule for the shift-register priority queue.
// Key/value widths live here so every stage agrees on the cell layout.
package pq_pkg;

  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;
  localparam int KV_WIDTH  = KEY_WIDTH + VAL_WIDTH;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  typedef struct packed {
    logic valid;
    kv_t  kv;
  } cell_t;

  // Strict compare: ties never win, so equal keys keep arrival order.
  function automatic logic better(
    input kv_t  a,
    input kv_t  b,
    input logic min_first
  );
    return min_first ? (a.key < b.key) : (a.key > b.key);
  endfunction

endpackage

// File: rtl/sr_pq_gen_cell.sv
// One queue stage: picks its next contents from hold, left, right or kvi.
// Combinational; the top owns the cell registers.
module sr_pq_cell
  import pq_pkg::*;
#(
  parameter bit HEAD = 1'b0
) (
  input  cell_t self,
  input  cell_t left,
  input  cell_t right,
  input  kv_t   kvi,
  input  logic  enq,
  input  logic  deq,
  input  logic  ins,
  input  logic  left_ins,
  input  logic  right_ins,
  output cell_t next
);

  // Select next cell contents for insert, remove or replace.
  always_comb begin
    next = self;
    unique case (1'b1)
      enq && deq: begin
        if (!HEAD && ins) begin
          next = self;
        end else if (right_ins) begin
          next = '{valid: 1'b1, kv: kvi};
        end else begin
          next = right;
        end
      end
      enq && !deq: begin
        if (ins) begin
          next = left_ins ? left : '{valid: 1'b1, kv: kvi};
        end
      end
      deq && !enq: begin
        next = right;
      end
      default: begin
        next = self;
      end
    endcase
  end

endmodule

// File: rtl/sr_pq_gen.sv
// Sorted shift-register priority queue with occupancy and overflow flags.
// Define SR_PQ_EVICT_EN to evict the worst entry on overflow.
module sr_pq_gen
  import pq_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter bit MIN_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enq,
  input  logic                       deq,
  input  logic [KV_WIDTH-1:0]        kvi,
  output logic [KV_WIDTH-1:0]        kvo,
  output logic                       ovalid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf
`ifdef SR_PQ_EVICT_EN
  ,
  output logic                       evict_valid,
  output logic [KV_WIDTH-1:0]        evict_kv
`endif
);

  localparam int CW = $clog2(DEPTH+1);

  cell_t            q  [DEPTH];
  cell_t            nq [DEPTH];
  logic [DEPTH-1:0] ins;
  kv_t              kv_in;
  logic             both;
  logic             ins_op;
  logic             del_op;
  logic             tail_ok;
  logic             ovf_set;
  logic             cell_en;
  logic             cell_de;

  assign kv_in  = kvi;
  assign ovalid = q[0].valid;
  assign empty  = !q[0].valid;
  assign full   = q[DEPTH-1].valid;
  assign kvo    = q[0].valid ? q[0].kv : '0;

`ifdef SR_PQ_EVICT_EN
  assign tail_ok = ins[DEPTH-1];
`else
  assign tail_ok = 1'b0;
`endif

  assign both    = enq && deq && !empty;
  assign ins_op  = enq && !both && (!full || tail_ok);
  assign del_op  = deq && !enq && !empty;
  assign ovf_set = enq && !both && full;
  assign cell_en = ins_op || both;
  assign cell_de = del_op || both;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    cell_t left;
    cell_t right;
    logic  lins;
    logic  rins;

    assign ins[i] = !q[i].valid
                 || better(kv_in, q[i].kv, MIN_FIRST);

    if (i == 0) begin : g_l0
      assign left = '0;
      assign lins = 1'b0;
    end else begin : g_ln
      assign left = q[i-1];
      assign lins = ins[i-1];
    end

    if (i == DEPTH-1) begin : g_rl
      assign right = '0;
      assign rins  = 1'b1;
    end else begin : g_rn
      assign right = q[i+1];
      assign rins  = ins[i+1];
    end

    sr_pq_cell #(
      .HEAD (i == 0)
    ) u_cell (
      .self      (q[i]),
      .left      (left),
      .right     (right),
      .kvi       (kv_in),
      .enq       (cell_en),
      .deq       (cell_de),
      .ins       (ins[i]),
      .left_ins  (lins),
      .right_ins (rins),
      .next      (nq[i])
    );
  end

  // Cell registers update together whenever a move is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (cell_en || cell_de) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= nq[i];
    end
  end

  // Occupancy is a popcount of the registered valid bits.
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(q[i].valid);
    end
  end

  // Overflow stays set until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
  end

`ifdef SR_PQ_EVICT_EN
  // Report the entry pushed out (old tail or refused kvi) for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evict_valid <= 1'b0;
      evict_kv    <= '0;
    end else begin
      evict_valid <= ovf_set;
      if (ovf_set) evict_kv <= tail_ok ? q[DEPTH-1].kv : kv_in;
    end
  end
`endif

endmodule

// File: tb/tb_sr_pq_gen.sv
// Randomised and directed bench for sr_pq_gen against a list model.
// Instance a is min-first, instance b is max-first, both DEPTH=4.
module tb_sr_pq_gen;
  import pq_pkg::*;

  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  typedef struct {
    int key;
    int val;
    int seq;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                enq_a = 0, deq_a = 0, enq_b = 0, deq_b = 0;
  logic [KV_WIDTH-1:0] kvi_a = '0, kvi_b = '0;
  logic [KV_WIDTH-1:0] kvo_a, kvo_b;
  logic                ovalid_a, empty_a, full_a, ovf_a;
  logic                ovalid_b, empty_b, full_b, ovf_b;
  logic [CW-1:0]       count_a, count_b;
`ifdef SR_PQ_EVICT_EN
  logic                ev_v_a, ev_v_b;
  logic [KV_WIDTH-1:0] ev_kv_a, ev_kv_b;
`endif

  sr_pq_gen #(.DEPTH(D), .MIN_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enq(enq_a), .deq(deq_a),
    .kvi(kvi_a), .kvo(kvo_a), .ovalid(ovalid_a),
    .empty(empty_a), .full(full_a), .count(count_a),
    .ovf(ovf_a)
`ifdef SR_PQ_EVICT_EN
    , .evict_valid(ev_v_a), .evict_kv(ev_kv_a)
`endif
  );

  sr_pq_gen #(.DEPTH(D), .MIN_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enq(enq_b), .deq(deq_b),
    .kvi(kvi_b), .kvo(kvo_b), .ovalid(ovalid_b),
    .empty(empty_b), .full(full_b), .count(count_b),
    .ovf(ovf_b)
`ifdef SR_PQ_EVICT_EN
    , .evict_valid(ev_v_b), .evict_kv(ev_kv_b)
`endif
  );

  int checks = 0;
  int failures = 0;

  ent_t          ma[$];
  ent_t          mb[$];
  bit            movf [2];
  bit            mev_v;
  logic [15:0]   mev_kv;
  int            seq_n = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit mbetter(int a, int b, bit mf);
    return mf ? (a < b) : (a > b);
  endfunction

  // Best = best key, earliest arrival among ties.
  function automatic int best_idx(ent_t m[$], bit mf);
    int bi = 0;
    for (int j = 1; j < m.size(); j++)
      if (mbetter(m[j].key, m[bi].key, mf)) bi = j;
    return bi;
  endfunction

  // Worst = worst key, latest arrival among ties.
  function automatic int worst_idx(ent_t m[$], bit mf);
    int wi = 0;
    for (int j = 1; j < m.size(); j++)
      if (!mbetter(m[j].key, m[wi].key, mf)) wi = j;
    return wi;
  endfunction

  task automatic m_apply(input int inst, input bit e, input bit d,
                         input int key, input int val);
    ent_t m[$];
    ent_t ne;
    bit   mf;
    int   n;
    int   w;
    if (inst == 0) m = ma; else m = mb;
    mf = (inst == 0);
    n = m.size();
    ne = '{key: key, val: val, seq: seq_n};
    mev_v = 1'b0;
    if (e) seq_n++;
    if (e && d && n > 0) begin
      m.delete(best_idx(m, mf));
      m.push_back(ne);
    end else if (e) begin
      if (n < D) begin
        m.push_back(ne);
      end else begin
        movf[inst] = 1'b1;
`ifdef SR_PQ_EVICT_EN
        mev_v = 1'b1;
        w = worst_idx(m, mf);
        if (mbetter(key, m[w].key, mf)) begin
          mev_kv = {8'(m[w].key), 8'(m[w].val)};
          m.delete(w);
          m.push_back(ne);
        end else begin
          mev_kv = {8'(key), 8'(val)};
        end
`else
        w = 0;
`endif
      end
    end else if (d && n > 0) begin
      m.delete(best_idx(m, mf));
    end
    if (inst == 0) ma = m; else mb = m;
  endtask

  task automatic check_all(input int inst);
    ent_t          m[$];
    logic [15:0]   ek;
    int            bi;
    string         p;
    if (inst == 0) m = ma; else m = mb;
    p = (inst == 0) ? "a" : "b";
    ek = '0;
    if (m.size() > 0) begin
      bi = best_idx(m, inst == 0);
      ek = {8'(m[bi].key), 8'(m[bi].val)};
    end
    if (inst == 0) begin
      check({p, "_kvo"}, 32'(kvo_a), 32'(ek));
      check({p, "_count"}, 32'(count_a), 32'(m.size()));
      check({p, "_empty"}, 32'(empty_a), 32'(m.size() == 0));
      check({p, "_ovalid"}, 32'(ovalid_a), 32'(m.size() != 0));
      check({p, "_full"}, 32'(full_a), 32'(m.size() == D));
      check({p, "_ovf"}, 32'(ovf_a), 32'(movf[0]));
`ifdef SR_PQ_EVICT_EN
      check({p, "_ev_v"}, 32'(ev_v_a), 32'(mev_v));
      if (mev_v) check({p, "_ev_kv"}, 32'(ev_kv_a), 32'(mev_kv));
`endif
    end else begin
      check({p, "_kvo"}, 32'(kvo_b), 32'(ek));
      check({p, "_count"}, 32'(count_b), 32'(m.size()));
      check({p, "_empty"}, 32'(empty_b), 32'(m.size() == 0));
      check({p, "_ovalid"}, 32'(ovalid_b), 32'(m.size() != 0));
      check({p, "_full"}, 32'(full_b), 32'(m.size() == D));
      check({p, "_ovf"}, 32'(ovf_b), 32'(movf[1]));
`ifdef SR_PQ_EVICT_EN
      check({p, "_ev_v"}, 32'(ev_v_b), 32'(mev_v));
      if (mev_v) check({p, "_ev_kv"}, 32'(ev_kv_b), 32'(mev_kv));
`endif
    end
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input int inst, input bit e, input bit d,
                      input int key, input int val);
    if (inst == 0) begin
      enq_a = e; deq_a = d; kvi_a = {8'(key), 8'(val)};
    end else begin
      enq_b = e; deq_b = d; kvi_b = {8'(key), 8'(val)};
    end
    @(posedge clk);
    #1;
    m_apply(inst, e, d, key, val);
    check_all(inst);
    @(negedge clk);
    enq_a = 0; deq_a = 0; enq_b = 0; deq_b = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_empty_a", 32'(empty_a), 32'd1);
    check("rst_count_a", 32'(count_a), 32'd0);
    check("rst_empty_b", 32'(empty_b), 32'd1);
    check("rst_count_b", 32'(count_b), 32'd0);
    ma.delete();
    mb.delete();
    movf[0] = 1'b0;
    movf[1] = 1'b0;
    mev_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check_all(0);
    check_all(1);

    // 1: single enq
    step(0, 1, 0, 8, 14);
    check("t1_kvo", 32'(kvo_a), 32'h080E);
    check("t1_count", 32'(count_a), 32'd1);
    // 2: replace head
    step(0, 1, 1, 2, 12);
    check("t2_kvo", 32'(kvo_a), 32'h020C);
    check("t2_count", 32'(count_a), 32'd1);
    step(0, 0, 1, 0, 0);
    check("t2_gone", 32'(empty_a), 32'd1);

    // 3: FIFO among equal keys
    step(0, 1, 0, 9, 10);
    step(0, 1, 0, 9, 11);
    step(0, 1, 0, 9, 12);
    check("t3_h0", 32'(kvo_a), 32'h090A);
    step(0, 0, 1, 0, 0);
    check("t3_h1", 32'(kvo_a), 32'h090B);
    step(0, 0, 1, 0, 0);
    check("t3_h2", 32'(kvo_a), 32'h090C);
    step(0, 0, 1, 0, 0);
    check("t3_empty", 32'(empty_a), 32'd1);
    step(0, 0, 1, 0, 0);
    check("t3_xdeq", 32'(count_a), 32'd0);

    // 4: overflow
    do_reset();
    step(0, 1, 0, 9, 0);
    step(0, 1, 0, 4, 0);
    step(0, 1, 0, 6, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 3, 13);
    check("t4_ovf", 32'(ovf_a), 32'd1);
    check("t4_full", 32'(full_a), 32'd1);
    check("t4_kvo", 32'(kvo_a), 32'h0100);
`ifdef SR_PQ_EVICT_EN
    check("t4_ev_key", 32'(ev_kv_a[15:8]), 32'd9);
    step(0, 0, 0, 0, 0);
    check("t4_ev_drop", 32'(ev_v_a), 32'd0);
    step(0, 1, 0, 10, 0);
    check("t4_ev_new", 32'(ev_kv_a), 32'h0A00);
`endif

    // 5: replace while full
    do_reset();
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 4, 0);
    step(0, 1, 0, 6, 0);
    step(0, 1, 0, 9, 0);
    step(0, 1, 1, 5, 0);
    check("t5_kvo", 32'(kvo_a[15:8]), 32'd4);
    check("t5_count", 32'(count_a), 32'd4);
    check("t5_ovf", 32'(ovf_a), 32'd0);
    step(0, 0, 1, 0, 0);
    check("t5_k5", 32'(kvo_a[15:8]), 32'd5);
    step(0, 0, 1, 0, 0);
    check("t5_k6", 32'(kvo_a[15:8]), 32'd6);
    step(0, 0, 1, 0, 0);
    check("t5_k9", 32'(kvo_a[15:8]), 32'd9);

    // 6: max-first and mid-sequence reset
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 5, 0);
    step(1, 1, 0, 3, 0);
    check("t6_k5", 32'(kvo_b[15:8]), 32'd5);
    step(1, 0, 1, 0, 0);
    check("t6_k3", 32'(kvo_b[15:8]), 32'd3);
    step(1, 0, 1, 0, 0);
    check("t6_k1", 32'(kvo_b[15:8]), 32'd1);
    step(1, 1, 0, 7, 1);
    do_reset();

    // Random traffic on both orderings.
    for (int inst = 0; inst < 2; inst++) begin
      for (int n = 0; n < 400; n++) begin
        int r;
        r = int'($urandom_range(0, 9));
        step(inst, r < 6, (r >= 4) && (r != 9),
             int'($urandom_range(0, 7)),
             int'($urandom_range(0, 255)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
